countdown_timer: RTL and testbench

Minute/second/tenth countdown timer: the counterpart to the team's up-counting stopwatch. It loads a BCD preset, counts down once per tenth-second tick from an internal prescaler, and raises a one-cycle `done_tick` plus a level `expired` flag when it reaches 0:00.0. It sits beside the stopwatch in the display/timing subsystem and drives the same 7-segment digit multiplexer.

---
 rtl/countdown_timer_if.sv | 38 +++
 rtl/countdown_timer.sv | 190 +++++++++++++++++++
 tb/tb_countdown_timer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// countdown_timer_if
//   Bundles the control, preset and display/status signals of the
//   countdown timer.
//
//   Handshake: there is no ready path. load/start/pause are sampled on
//   every rising clk edge without acknowledgement. d3..d0, running,
//   expired and state_dbg are levels that are valid in every cycle.
//   done_tick is a single-cycle strobe that marks the first cycle in DONE.
//
//   master: drives load/start/pause/preset_*, observes the outputs.
//   slave : the timer itself.
interface countdown_timer_if;
    logic       load;
    logic       start;
    logic       pause;
    logic [3:0] preset_m;
    logic [2:0] preset_s1;
    logic [3:0] preset_s0;
    logic [3:0] preset_t;
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       running;
    logic       expired;
    logic       done_tick;
    logic [1:0] state_dbg;

    modport master (
        output load, start, pause, preset_m, preset_s1, preset_s0, preset_t,
        input  d3, d2, d1, d0, running, expired, done_tick, state_dbg
    );

    modport slave (
        input  load, start, pause, preset_m, preset_s1, preset_s0, preset_t,
        output d3, d2, d1, d0, running, expired, done_tick, state_dbg
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer
//   Minute/second/tenth BCD countdown timer. A preset is loaded in IDLE,
//   counted down once per prescaler tick in RUN, frozen in PAUSE, and the
//   timer parks in DONE at 0:00.0 with a one-cycle done_tick on entry.
//
//   Parameters:
//     DVSR - clk cycles per tenth-second tick (>= 2)
//     PW   - prescaler width, 2**PW > DVSR-1
//   Ports:
//     clk   - system clock
//     reset - asynchronous, active-high
//     tif   - countdown_timer_if.slave (controls, presets, digits, status,
//             state_dbg exposes the FSM state encoding)
module countdown_timer #(
    parameter int DVSR = 5000000,
    parameter int PW   = 23
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  tif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [PW-1:0] PRESC_MAX = PW'(DVSR - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    m_q,  m_d;
    logic [2:0]    s1_q, s1_d;
    logic [3:0]    s0_q, s0_d;
    logic [3:0]    t_q,  t_d;
    logic          done_tick_q;

    // Clamped preset digits.
    logic [3:0] ld_m, ld_s0, ld_t;
    logic [2:0] ld_s1;

    assign ld_m  = (tif.preset_m  > 4'd9) ? 4'd9 : tif.preset_m;
    assign ld_s1 = (tif.preset_s1 > 3'd5) ? 3'd5 : tif.preset_s1;
    assign ld_s0 = (tif.preset_s0 > 4'd9) ? 4'd9 : tif.preset_s0;
    assign ld_t  = (tif.preset_t  > 4'd9) ? 4'd9 : tif.preset_t;

    logic tick;
    logic digits_zero;
    logic last_tenth;

    assign tick        = (presc_q == PRESC_MAX);
    assign digits_zero = (m_q == 4'd0) && (s1_q == 3'd0) && (s0_q == 4'd0) && (t_q == 4'd0);
    // One tenth left: the next tick lands on 0:00.0 and ends the count.
    assign last_tenth  = (m_q == 4'd0) && (s1_q == 3'd0) && (s0_q == 4'd0) && (t_q == 4'd1);

    // BCD borrow chain t -> s0 -> s1 -> m.
    logic [3:0] dec_m, dec_s0, dec_t;
    logic [2:0] dec_s1;

    always_comb begin
        dec_m  = m_q;
        dec_s1 = s1_q;
        dec_s0 = s0_q;
        dec_t  = t_q;
        if (t_q != 4'd0) begin
            dec_t = t_q - 4'd1;
        end else begin
            dec_t = 4'd9;
            if (s0_q != 4'd0) begin
                dec_s0 = s0_q - 4'd1;
            end else begin
                dec_s0 = 4'd9;
                if (s1_q != 3'd0) begin
                    dec_s1 = s1_q - 3'd1;
                end else begin
                    dec_s1 = 3'd5;
                    // m is never zero here while counting; the guard keeps
                    // the minutes digit from wrapping regardless.
                    if (m_q != 4'd0) begin
                        dec_m = m_q - 4'd1;
                    end
                end
            end
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        m_d     = m_q;
        s1_d    = s1_q;
        s0_d    = s0_q;
        t_d     = t_q;
        case (state_q)
            IDLE: begin
                if (tif.load) begin
                    m_d  = ld_m;
                    s1_d = ld_s1;
                    s0_d = ld_s0;
                    t_d  = ld_t;
                end else if (tif.start && !digits_zero) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (last_tenth) begin
                        // Expiry beats a coincident pause.
                        m_d     = 4'd0;
                        s1_d    = 3'd0;
                        s0_d    = 4'd0;
                        t_d     = 4'd0;
                        state_d = DONE;
                    end else begin
                        m_d  = dec_m;
                        s1_d = dec_s1;
                        s0_d = dec_s0;
                        t_d  = dec_t;
                        if (tif.pause) begin
                            state_d = PAUSE;
                        end
                    end
                end else if (tif.pause) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (tif.load) begin
                    m_d     = ld_m;
                    s1_d    = ld_s1;
                    s0_d    = ld_s0;
                    t_d     = ld_t;
                    presc_d = '0;
                    state_d = IDLE;
                end else if (tif.start) begin
                    // Prescaler resumes from its held phase.
                    state_d = RUN;
                end
            end
            DONE: begin
                if (tif.load) begin
                    m_d     = ld_m;
                    s1_d    = ld_s1;
                    s0_d    = ld_s0;
                    t_d     = ld_t;
                    presc_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            m_q         <= 4'd0;
            s1_q        <= 3'd0;
            s0_q        <= 4'd0;
            t_q         <= 4'd0;
            done_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            m_q         <= m_d;
            s1_q        <= s1_d;
            s0_q        <= s0_d;
            t_q         <= t_d;
            done_tick_q <= (state_q == RUN) && (state_d == DONE);
        end
    end

    assign tif.d3        = m_q;
    assign tif.d2        = {1'b0, s1_q};
    assign tif.d1        = s0_q;
    assign tif.d0        = t_q;
    assign tif.running   = (state_q == RUN);
    assign tif.expired   = (state_q == DONE);
    assign tif.done_tick = done_tick_q;
    assign tif.state_dbg = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//   Directed bench for countdown_timer with DVSR = 2. Stimulus pushes the
//   expected outputs for future cycles into exp_q and the expected
//   done_tick cycles into exp_done_q; an independent monitor compares on
//   every falling edge.
module tb_countdown_timer;

    localparam int DVSR = 2;
    localparam int W    = 51;   // {cycle[31:0], d3,d2,d1,d0, running, expired, done_tick}

    logic clk;
    logic reset;
    int   cyc;

    countdown_timer_if tif ();

    countdown_timer #(.DVSR(DVSR), .PW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .tif   (tif.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [W-1:0]  exp_q[$];
    logic [31:0]   exp_done_q[$];
    int            n_compared;
    int            n_mismatched;

    task automatic expect_at(input int c, input logic [3:0] a3, a2, a1, a0,
                             input logic r, e, dt);
        logic [31:0] cc;
        cc = c;
        exp_q.push_back({cc, a3, a2, a1, a0, r, e, dt});
    endtask

    task automatic expect_done(input int c);
        logic [31:0] cc;
        cc = c;
        exp_done_q.push_back(cc);
    endtask

    // Monitor
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && int'(exp_q[0][50:19]) <= cyc) begin
                logic [W-1:0] e;
                logic [18:0]  act;
                e   = exp_q.pop_front();
                act = {tif.d3, tif.d2, tif.d1, tif.d0, tif.running, tif.expired, tif.done_tick};
                n_compared++;
                if (int'(e[50:19]) != cyc || act != e[18:0]) begin
                    n_mismatched++;
                    $display("FAIL outputs@%0d (want cycle %0d): got d=%h%h%h%h run=%b exp=%b dt=%b, want d=%h%h%h%h run=%b exp=%b dt=%b",
                             cyc, e[50:19], act[18:15], act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                             e[18:15], e[14:11], e[10:7], e[6:3], e[2], e[1], e[0]);
                end
            end
            while (exp_done_q.size() > 0 && int'(exp_done_q[0]) < cyc) begin
                logic [31:0] d;
                d = exp_done_q.pop_front();
                n_compared++;
                n_mismatched++;
                $display("FAIL done_tick_missing: got none, want pulse at cycle %0d", d);
            end
            if (tif.done_tick) begin
                n_compared++;
                if (exp_done_q.size() == 0 || int'(exp_done_q[0]) != cyc) begin
                    n_mismatched++;
                    $display("FAIL done_tick_unexpected: got pulse at cycle %0d, want %0d", cyc,
                             (exp_done_q.size() == 0) ? -1 : int'(exp_done_q[0]));
                end else begin
                    void'(exp_done_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ld, st, ps,
                         input logic [3:0] m, input logic [2:0] s1,
                         input logic [3:0] s0, input logic [3:0] t,
                         output int k);
        @(negedge clk);
        tif.load      = ld;
        tif.start     = st;
        tif.pause     = ps;
        tif.preset_m  = m;
        tif.preset_s1 = s1;
        tif.preset_s0 = s0;
        tif.preset_t  = t;
        k = cyc + 1;
    endtask

    task automatic release_in();
        @(negedge clk);
        tif.load  = 1'b0;
        tif.start = 1'b0;
        tif.pause = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int k, l;

    initial begin
        reset         = 1'b1;
        tif.load      = 1'b0;
        tif.start     = 1'b0;
        tif.pause     = 1'b0;
        tif.preset_m  = 4'd0;
        tif.preset_s1 = 3'd0;
        tif.preset_s0 = 4'd0;
        tif.preset_t  = 4'd0;

        // Reset state
        expect_at(1, 0, 0, 0, 0, 0, 0, 0);
        wait_until(2);
        reset = 1'b0;

        // 0:00.3 countdown
        drive(1, 0, 0, 0, 0, 0, 3, l);
        expect_at(l, 0, 0, 0, 3, 0, 0, 0);
        release_in();
        drive(0, 1, 0, 0, 0, 0, 3, k);
        expect_at(k,     0, 0, 0, 3, 1, 0, 0);
        expect_at(k + 1, 0, 0, 0, 3, 1, 0, 0);
        expect_at(k + 2, 0, 0, 0, 2, 1, 0, 0);
        expect_at(k + 4, 0, 0, 0, 1, 1, 0, 0);
        expect_at(k + 6, 0, 0, 0, 0, 0, 1, 1);
        expect_at(k + 7, 0, 0, 0, 0, 0, 1, 0);
        expect_at(k + 9, 0, 0, 0, 0, 0, 1, 0);
        expect_done(k + 6);
        release_in();
        wait_until(k + 9);

        // 1:00.0: full borrow chain, then run to expiry
        drive(1, 0, 0, 1, 0, 0, 0, l);
        expect_at(l, 1, 0, 0, 0, 0, 0, 0);
        release_in();
        drive(0, 1, 0, 0, 0, 0, 0, k);
        expect_at(k,        1, 0, 0, 0, 1, 0, 0);
        expect_at(k + 2,    0, 5, 9, 9, 1, 0, 0);
        expect_at(k + 4,    0, 5, 9, 8, 1, 0, 0);
        expect_at(k + 1200, 0, 0, 0, 0, 0, 1, 1);
        expect_done(k + 1200);
        release_in();
        wait_until(k + 1201);

        // 0:00.5 with a 10-cycle pause after 5 counting cycles
        drive(1, 0, 0, 0, 0, 0, 5, l);
        expect_at(l, 0, 0, 0, 5, 0, 0, 0);
        release_in();
        drive(0, 1, 0, 0, 0, 0, 5, k);
        expect_at(k + 2,  0, 0, 0, 4, 1, 0, 0);
        expect_at(k + 4,  0, 0, 0, 3, 1, 0, 0);
        expect_at(k + 5,  0, 0, 0, 3, 0, 0, 0);
        expect_at(k + 10, 0, 0, 0, 3, 0, 0, 0);
        expect_at(k + 14, 0, 0, 0, 3, 0, 0, 0);
        expect_at(k + 15, 0, 0, 0, 3, 1, 0, 0);
        expect_at(k + 16, 0, 0, 0, 2, 1, 0, 0);
        expect_at(k + 18, 0, 0, 0, 1, 1, 0, 0);
        expect_at(k + 20, 0, 0, 0, 0, 0, 1, 1);
        expect_at(k + 21, 0, 0, 0, 0, 0, 1, 0);
        expect_done(k + 20);
        release_in();
        wait_until(k + 4);
        tif.pause = 1'b1;
        wait_until(k + 14);
        tif.pause = 1'b0;
        tif.start = 1'b1;
        wait_until(k + 15);
        tif.start = 1'b0;
        wait_until(k + 21);

        // Out-of-range preset clamps (loaded from DONE)
        drive(1, 0, 0, 4'd12, 3'd7, 4'd15, 4'd10, l);
        expect_at(l, 9, 5, 9, 9, 0, 0, 0);
        release_in();

        // Zero preset: start ignored
        drive(1, 0, 0, 0, 0, 0, 0, l);
        expect_at(l, 0, 0, 0, 0, 0, 0, 0);
        release_in();
        drive(0, 1, 0, 0, 0, 0, 0, k);
        expect_at(k,     0, 0, 0, 0, 0, 0, 0);
        expect_at(k + 3, 0, 0, 0, 0, 0, 0, 0);
        release_in();
        wait_until(k + 3);

        // load + start together: load wins, stay IDLE
        drive(1, 1, 0, 0, 0, 0, 2, l);
        expect_at(l,     0, 0, 0, 2, 0, 0, 0);
        expect_at(l + 2, 0, 0, 0, 2, 0, 0, 0);
        release_in();
        wait_until(l + 2);
        drive(0, 1, 0, 0, 0, 0, 2, k);
        expect_at(k,     0, 0, 0, 2, 1, 0, 0);
        expect_at(k + 2, 0, 0, 0, 1, 1, 0, 0);
        expect_at(k + 4, 0, 0, 0, 0, 0, 1, 1);
        expect_done(k + 4);
        release_in();
        wait_until(k + 5);

        // Reload from DONE with 0:01.0, then count it out
        drive(1, 0, 0, 0, 0, 1, 0, l);
        expect_at(l, 0, 0, 1, 0, 0, 0, 0);
        release_in();
        drive(0, 1, 0, 0, 0, 1, 0, k);
        expect_at(k,      0, 0, 1, 0, 1, 0, 0);
        expect_at(k + 2,  0, 0, 0, 9, 1, 0, 0);
        expect_at(k + 18, 0, 0, 0, 1, 1, 0, 0);
        expect_at(k + 20, 0, 0, 0, 0, 0, 1, 1);
        expect_done(k + 20);
        release_in();
        wait_until(k + 21);

        // Asynchronous reset pulse mid-RUN at 0:30.3 (between clock edges)
        drive(1, 0, 0, 0, 3, 0, 4, l);
        expect_at(l, 0, 3, 0, 4, 0, 0, 0);
        release_in();
        drive(0, 1, 0, 0, 3, 0, 4, k);
        expect_at(k + 2, 0, 3, 0, 3, 1, 0, 0);
        expect_at(k + 3, 0, 3, 0, 3, 1, 0, 0);
        expect_at(k + 4, 0, 0, 0, 0, 0, 0, 0);
        expect_at(k + 8, 0, 0, 0, 0, 0, 0, 0);
        release_in();
        wait_until(k + 3);
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        wait_until(k + 8);
        drive(0, 1, 0, 0, 3, 0, 4, l);
        expect_at(l,     0, 0, 0, 0, 0, 0, 0);
        expect_at(l + 2, 0, 0, 0, 0, 0, 0, 0);
        release_in();
        wait_until(l + 4);

        // Anything left unmatched counts against the run
        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL exp_q_leftover: got %0d pending, want 0", exp_q.size());
        end
        if (exp_done_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL done_leftover: got %0d pending, want 0", exp_done_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
